// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud_set encodings and the
// elaboration-time baud divisor function used by the 16x oversampling logic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_t;

  localparam int SAMPLE_LO = 6;
  localparam int SAMPLE_HI = 12;
  localparam int SUB_LAST  = 15;

  // Codes 5..7 fall back to the fastest rate, matching the transmitter.
  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      BAUD_38400: rate = 38400;
      BAUD_57600: rate = 57600;
      default:    rate = 115200;
    endcase
    return rate;
  endfunction

  function automatic int baud_div(input int clk_freq, input logic [2:0] sel);
    int rate;
    rate = baud_rate(sel);
    return (clk_freq + 8 * rate) / (16 * rate);
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Receiver result bundle: the received byte plus its one-cycle status strobes.
interface uart_byte_rx_if;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       uart_state;

  modport master (
    output data_byte,
    output rx_done,
    output frame_err,
    output parity_err,
    output uart_state
  );

  modport slave (
    input data_byte,
    input rx_done,
    input frame_err,
    input parity_err,
    input uart_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// 16x subsample tick generator: counts 0..div-1 and pulses tick on the last count.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == div - 1'b1);

  // Held at zero while disabled so every frame starts on a fresh subsample.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 7-sample majority voting.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 20_000_000,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     baud_set,
  input  logic           rs232_rx,
  uart_byte_rx_if.master rx_if
);

  localparam int SUB_W = $clog2(OVERSAMPLE);

  localparam logic [15:0] DIV_9600   = 16'(baud_div(CLK_FREQ, BAUD_9600));
  localparam logic [15:0] DIV_19200  = 16'(baud_div(CLK_FREQ, BAUD_19200));
  localparam logic [15:0] DIV_38400  = 16'(baud_div(CLK_FREQ, BAUD_38400));
  localparam logic [15:0] DIV_57600  = 16'(baud_div(CLK_FREQ, BAUD_57600));
  localparam logic [15:0] DIV_115200 = 16'(baud_div(CLK_FREQ, BAUD_115200));

  logic             sync1;
  logic             sync2;
  logic             rx_prev;
  logic             start_edge;

  rx_state_t        state;
  logic [15:0]      div_sel;
  logic [15:0]      div_lat;
  logic             tick;
  logic [SUB_W-1:0] sub_idx;
  logic [2:0]       bit_idx;
  logic [2:0]       vote_sum;
  logic [2:0]       vote_next;
  logic             in_window;
  logic             majority;
  logic [7:0]       shift_reg;

  logic [7:0]       data_q;
  logic             rx_done_q;
  logic             frame_err_q;
  logic             busy_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
  logic             parity_err_q;
`endif

  // Two flops resolve metastability; the third gives the previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rs232_rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign start_edge = rx_prev && !sync2;

  always_comb begin
    div_sel = DIV_115200;
    case (baud_set)
      BAUD_9600:  div_sel = DIV_9600;
      BAUD_19200: div_sel = DIV_19200;
      BAUD_38400: div_sel = DIV_38400;
      BAUD_57600: div_sel = DIV_57600;
      default:    div_sel = DIV_115200;
    endcase
  end

  uart_baud_tick #(
    .DIV_W (16)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state == IDLE) && start_edge),
    .enable (state != IDLE),
    .div    (div_lat),
    .tick   (tick)
  );

  // The vote includes the sample taken on the deciding subsample itself.
  assign in_window = (sub_idx >= SUB_W'(SAMPLE_LO)) && (sub_idx <= SUB_W'(SAMPLE_HI));
  assign vote_next = vote_sum + {2'b00, sync2};
  assign majority  = (vote_next >= 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_lat     <= DIV_115200;
      sub_idx     <= '0;
      bit_idx     <= '0;
      vote_sum    <= '0;
      shift_reg   <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      if (tick) begin
        sub_idx <= (sub_idx == SUB_W'(SUB_LAST)) ? '0 : sub_idx + 1'b1;
        if (in_window) begin
          vote_sum <= vote_next;
        end
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            busy_q   <= 1'b1;
            div_lat  <= div_sel;
            sub_idx  <= '0;
            bit_idx  <= '0;
            vote_sum <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (sub_idx == SUB_W'(SAMPLE_HI) && majority) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else if (sub_idx == SUB_W'(SUB_LAST)) begin
              state    <= DATA;
              bit_idx  <= '0;
              vote_sum <= '0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (sub_idx == SUB_W'(SAMPLE_HI)) begin
              shift_reg[bit_idx] <= majority;
            end
            if (sub_idx == SUB_W'(SUB_LAST)) begin
              vote_sum <= '0;
              bit_idx  <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (sub_idx == SUB_W'(SAMPLE_HI)) begin
              par_bit <= majority;
            end
            if (sub_idx == SUB_W'(SUB_LAST)) begin
              vote_sum <= '0;
              state    <= STOP;
            end
          end
        end
`endif

        // Decide at subsample 12 so a zero-gap following start bit is not missed.
        STOP: begin
          if (tick && sub_idx == SUB_W'(SAMPLE_HI)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (majority) begin
              data_q    <= shift_reg;
              rx_done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bit ^ (^shift_reg) ^ PARITY_ODD;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data_byte  = data_q;
  assign rx_if.rx_done    = rx_done_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.uart_state = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frames are bit-banged onto rs232_rx and
// each rx_done is checked against the queue of bytes sent.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud_set;
  logic       rs232_rx;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(
    .CLK_FREQ   (20_000_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_set (baud_set),
    .rs232_rx (rs232_rx),
    .rx_if    (rx_if)
  );

  always #25 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         overlap_cnt = 0;
  int         double_cnt = 0;
  int         busy_cur = 0;
  int         busy_last = 0;
  logic       prev_done = 1'b0;

  function automatic int ref_div(input logic [2:0] sel);
    case (sel)
      3'd0:    return 130;
      3'd1:    return 65;
      3'd2:    return 33;
      3'd3:    return 22;
      default: return 11;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_line(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // spike_bit >= 0 inverts the line for 2 subsamples centred in that bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int spike_bit);
    int sub;
    sub = ref_div(baud_set);
    if (stop_val) exp_q.push_back(data);
    drive_line(1'b0, 16 * sub);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) begin
        drive_line(data[i], 7 * sub);
        drive_line(~data[i], 2 * sub);
        drive_line(data[i], 7 * sub);
      end else begin
        drive_line(data[i], 16 * sub);
      end
    end
`ifdef UART_RX_PARITY_EN
    drive_line(^data, 16 * sub);
`endif
    drive_line(stop_val, 16 * sub);
    rs232_rx = 1'b1;
  endtask

  task automatic idle_bits(input int nbits);
    drive_line(1'b1, nbits * 16 * ref_div(baud_set));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rx_if.rx_done) begin
        done_cnt++;
        if (prev_done) double_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("spurious_rx_done", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checkOutput("data_byte", {24'd0, rx_if.data_byte}, {24'd0, e});
          checkOutput("parity_err", {31'd0, rx_if.parity_err}, 32'd0);
        end
      end
      if (rx_if.frame_err) ferr_cnt++;
      if (rx_if.rx_done && rx_if.frame_err) overlap_cnt++;
      prev_done = rx_if.rx_done;
      if (rx_if.uart_state) begin
        busy_cur++;
      end else if (busy_cur != 0) begin
        busy_last = busy_cur;
        busy_cur  = 0;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_byte);
    checkOutput({tag, "_data_byte"}, {24'd0, rx_if.data_byte}, {24'd0, exp_byte});
    checkOutput({tag, "_rx_done"}, {31'd0, rx_if.rx_done}, 32'd0);
    checkOutput({tag, "_frame_err"}, {31'd0, rx_if.frame_err}, 32'd0);
    checkOutput({tag, "_parity_err"}, {31'd0, rx_if.parity_err}, 32'd0);
    checkOutput({tag, "_uart_state"}, {31'd0, rx_if.uart_state}, 32'd0);
  endtask

  task automatic run_tests();
    int d0;
    int f0;
    logic [7:0] abort_byte;

    rst      = 1'b1;
    rs232_rx = 1'b1;
    baud_set = 3'd4;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single frame 0x55 at 115200");
    d0 = done_cnt; f0 = ferr_cnt;
    applyStimulus(8'h55, 1'b1, -1);
    idle_bits(1);
    checkOutput("t1_done_count", done_cnt - d0, 1);
    checkOutput("t1_ferr_count", ferr_cnt - f0, 0);
    checkOutput("t1_frame_busy_len", {31'd0, (busy_last >= 1700 && busy_last <= 1760)}, 32'd1);
    check_idle_outputs("t1_after", 8'h55);

    $display("[TB] start glitch of 4 subsamples");
    d0 = done_cnt; f0 = ferr_cnt;
    drive_line(1'b0, 44);
    idle_bits(3);
    checkOutput("t2_done_count", done_cnt - d0, 0);
    checkOutput("t2_ferr_count", ferr_cnt - f0, 0);
    checkOutput("t2_glitch_busy_short", {31'd0, (busy_last > 0 && busy_last < 176)}, 32'd1);
    check_idle_outputs("t2_after", 8'h55);

    $display("[TB] framing error on 0xA3");
    d0 = done_cnt; f0 = ferr_cnt;
    applyStimulus(8'hA3, 1'b0, -1);
    idle_bits(3);
    checkOutput("t3_done_count", done_cnt - d0, 0);
    checkOutput("t3_ferr_count", ferr_cnt - f0, 1);
    check_idle_outputs("t3_after", 8'h55);

    $display("[TB] back-to-back 0xA5 0x3C");
    d0 = done_cnt; f0 = ferr_cnt;
    applyStimulus(8'hA5, 1'b1, -1);
    applyStimulus(8'h3C, 1'b1, -1);
    idle_bits(2);
    checkOutput("t4_done_count", done_cnt - d0, 2);
    checkOutput("t4_ferr_count", ferr_cnt - f0, 0);
    check_idle_outputs("t4_after", 8'h3C);

    $display("[TB] noise spike in bit 3");
    d0 = done_cnt;
    applyStimulus(8'hFF, 1'b1, 3);
    idle_bits(2);
    checkOutput("t5a_done_count", done_cnt - d0, 1);
    checkOutput("t5a_data_byte", {24'd0, rx_if.data_byte}, 32'h0000_00FF);
    baud_set = 3'd0;
    d0 = done_cnt;
    applyStimulus(8'h00, 1'b1, 3);
    idle_bits(2);
    checkOutput("t5b_done_count", done_cnt - d0, 1);
    checkOutput("t5b_data_byte", {24'd0, rx_if.data_byte}, 32'h0);

    $display("[TB] reset in the middle of bit 4");
    baud_set   = 3'd4;
    idle_bits(1);
    d0 = done_cnt; f0 = ferr_cnt;
    abort_byte = 8'h6E;
    drive_line(1'b0, 176);
    for (int i = 0; i < 4; i++) drive_line(abort_byte[i], 176);
    drive_line(abort_byte[4], 88);
    rst      = 1'b1;
    rs232_rx = 1'b1;
    @(negedge clk);
    check_idle_outputs("t6_reset", 8'h00);
    rst = 1'b0;
    idle_bits(3);
    checkOutput("t6_abort_done_count", done_cnt - d0, 0);
    checkOutput("t6_abort_ferr_count", ferr_cnt - f0, 0);
    applyStimulus(8'h81, 1'b1, -1);
    idle_bits(1);
    checkOutput("t6_done_count", done_cnt - d0, 1);
    check_idle_outputs("t6_after", 8'h81);

    checkOutput("double_pulses", double_cnt, 0);
    checkOutput("done_ferr_overlap", overlap_cnt, 0);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      begin
        run_tests();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
UART byte receiver; the receive-side counterpart that completes the loop-back path to the existing 8N1 transmitter.
- Deserialises an 8N1 frame from the rs232 line into a byte, with a one-cycle done strobe.
- Runs in the 20 MHz PLL domain and uses the same baud_set encoding as the transmitter.
- Output drives a byte consumer or echoes straight into the transmitter's data_byte/send_en.

Parameters:
CLK_FREQ, 20_000_000, system clock frequency in Hz.
OVERSAMPLE, 16, subsamples per bit. Fixed at 16; other values unsupported.

Ports:
clk  input  1  system clock, 20 MHz.
rst  input  1  synchronous, active-high reset.
baud_set  input  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=115200.
rs232_rx  input  1  asynchronous serial line; idle high.
data_byte  output  8  last correctly framed byte, LSB received first.
rx_done  output  1  one-cycle pulse when data_byte is updated.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
parity_err  output  1  one-cycle parity-failure pulse; constant 0 when the parity feature is compiled out.
uart_state  output  1  high while a frame is in progress.

Behaviour:
- Reset values: data_byte=0, rx_done=0, frame_err=0, parity_err=0, uart_state=0, FSM=IDLE, synchroniser flops=1.
- Reset is sampled every cycle, including mid-frame; it aborts the frame and produces no strobe.
- Input path:
  - rs232_rx passes through a 2-flop synchroniser, then one extra flop for edge detection.
  - A falling edge is detected when the previous sample is 1 and the current sample is 0.
- Baud tick:
  - Divisor DIV = (CLK_FREQ + 8*baud)/(16*baud), rounded integer, computed at elaboration for each rate. At 115200 DIV=11 (-1.4% error); at 9600 DIV=130.
  - Tick counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - The counter is cleared on start detect. It is idle (held at 0) in IDLE.
- baud_set is latched on start detect; changes mid-frame are ignored.
- Bit sampling:
  - Each bit occupies 16 ticks (subsample index 0..15).
  - Subsamples 6..12 (7 samples) are summed in a 3-bit counter.
  - Bit value = 1 if the sum >= 4, else 0.
- FSM:
  - IDLE: on falling edge go to START; uart_state rises the next cycle.
  - START: at subsample 12 evaluate the majority. If 1 (glitch), go to IDLE with no strobe. If 0, continue; at subsample 15 go to DATA with bit_idx=0.
  - DATA: at subsample 12, shift the majority bit into shift_reg[bit_idx]. At subsample 15, increment bit_idx; after bit 7 go to STOP, or to PARITY when parity is compiled in.
  - STOP: at subsample 12, the majority decides the outcome.
    - 1 → data_byte<=shift_reg and rx_done=1 for one cycle.
    - 0 → frame_err=1 for one cycle; data_byte is unchanged.
    - In both cases go to IDLE in the same cycle; uart_state falls the next cycle.
- Latency: the strobe is registered in the clk cycle after the tick that completes stop subsample 12, i.e. about 9.75 bit times after the start edge.
- Back-to-back frames: the FSM returns to IDLE 3 subsamples before the nominal stop end, so a start edge with zero idle gap is caught.
- Simultaneity: rx_done and frame_err are never high together. parity_err may coincide with rx_done; the byte is still delivered and flagged.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is start + 8 data + parity + stop.
  - PARITY state samples like a data bit.
  - parity_err pulses with the strobe if the received parity mismatches the even parity of the byte (parameter PARITY_ODD, default 0, selects odd parity).
- Undefined: no PARITY state; parity_err is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state typedef: IDLE, START, DATA, PARITY, STOP.
  - baud_set encodings.
  - Constant function baud_div(clk_freq, sel).
  - Constants SAMPLE_LO=6, SAMPLE_HI=12, SUB_LAST=15.
- Sub-module uart_baud_tick holds the divisor counter and tick generator. It is shared later with a 16x transmitter.

Test Plan:
1. baud_set=4, frame 0x55 → rx_done single pulse, data_byte=0x55, no frame_err, uart_state high for the frame only.
2. Start glitch: line low for 4 subsamples (44 clks) then high → no rx_done, no frame_err, FSM back in IDLE, uart_state pulse less than 1 bit time.
3. Stop bit driven 0 on byte 0xA3 → frame_err pulse, rx_done=0, data_byte keeps its previous value.
4. Back-to-back 0xA5 then 0x3C with zero idle gap at 115200 → two rx_done pulses, values in order, no errors.
5. Noise: 0xFF frame with a 2-subsample low spike centred in bit 3 → data_byte=0xFF. Same test at baud_set=0 (9600, DIV=130) with 0x00 → data_byte=0x00.
6. rst asserted for 1 cycle at bit 4 of a frame → all outputs 0 next cycle, no strobe. The following clean frame 0x81 is received correctly.
